// File: rtl/packed_q_pkg.sv
// Shared types for the packed-queue read engine: queue id and popped entry layout
// at the default geometry (16 queues, 32-bit payload).
package packed_q_pkg;

  localparam int unsigned DefBitsAddrPack = 4;
  localparam int unsigned DefDataWidth    = 32;

  typedef logic [DefBitsAddrPack-1:0] qid_t;

  typedef struct packed {
    qid_t                    qid;
    logic [DefDataWidth-1:0] data;
  } entry_t;

endpackage

// File: rtl/packed_q_out_buf.sv
// Two-entry in-order output buffer with valid/ready drain. The producer never pushes
// when full, so there is no backpressure toward the capture side.
module packed_q_out_buf #(
  parameter int unsigned Width = 36
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [1:0]       count
);

  logic [Width-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot0_q;
  assign count     = count_q;
  assign pop       = out_valid & out_ready;

  // slot0 is always the head; a pop shifts slot1 forward.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({in_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = in_data;
        else                 slot1_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = in_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/packed_q_rd_engine.sv
// Round-robin pop engine over packed logical queues: scans one queue per cycle, issues
// a synchronous RAM read on a non-empty queue and streams {qid, data} out in pop order.
module packed_q_rd_engine
  import packed_q_pkg::*;
#(
  parameter int unsigned BITS_ADDR_PACK   = DefBitsAddrPack,
  parameter int unsigned NUM_OF_Q         = 2 ** BITS_ADDR_PACK,
  parameter int unsigned BITS_ADDR_EACH_Q = 2,
  parameter int unsigned DATA_WIDTH       = DefDataWidth
) (
  input  logic                                 clk,
  input  logic                                 rst_b,
  input  logic                                 en,
  output logic [BITS_ADDR_PACK-1:0]            rd_addr,
  input  logic                                 q_empty,
  input  logic [BITS_ADDR_EACH_Q-1:0]          rd_ptr_val,
  output logic                                 rd_ptr_inc,
  output logic                                 ram_rd_en,
  output logic [BITS_ADDR_PACK+BITS_ADDR_EACH_Q-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]                ram_rd_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [BITS_ADDR_PACK-1:0]            out_qid
);

  localparam int unsigned EntryW = BITS_ADDR_PACK + DATA_WIDTH;
  localparam logic [BITS_ADDR_PACK-1:0] LastQ = BITS_ADDR_PACK'(NUM_OF_Q - 1);

  logic [BITS_ADDR_PACK-1:0] cand_q, cand_d, if_qid_q, if_qid_d;
  logic                      if_q, if_d, active_q, active_d;
  logic [1:0]                buf_count, total;
  logic                      drain, issue, step;
  logic [EntryW-1:0]         buf_out;

  assign total = buf_count + {1'b0, if_q};
  assign drain = out_valid & out_ready;

  // active_q holds off issue until the first edge after reset so nothing pops in reset.
  always_comb begin
    issue    = active_q & en & ~q_empty & ((total - {1'b0, drain}) < 2'd2);
    step     = issue | (active_q & en & q_empty);
    cand_d   = cand_q;
    if (step) cand_d = (cand_q == LastQ) ? '0 : cand_q + 1'b1;
    if_d     = issue;
    if_qid_d = issue ? cand_q : if_qid_q;
    active_d = 1'b1;
  end

  assign rd_addr     = cand_q;
  assign rd_ptr_inc  = issue;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = {cand_q, rd_ptr_val};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cand_q   <= '0;
      if_qid_q <= '0;
      if_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      if_qid_q <= if_qid_d;
      if_q     <= if_d;
      active_q <= active_d;
    end
  end

  packed_q_out_buf #(
    .Width(EntryW)
  ) u_out_buf (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_valid (if_q),
    .in_data  ({if_qid_q, ram_rd_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out),
    .count    (buf_count)
  );

  assign out_qid  = buf_out[EntryW-1:DATA_WIDTH];
  assign out_data = buf_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_packed_q_rd_engine.sv
// Directed bench for packed_q_rd_engine with a queue/pointer-manager and RAM model.
module tb_packed_q_rd_engine;
  import packed_q_pkg::*;

  localparam int BAP = 4;
  localparam int BEQ = 2;
  localparam int DW  = 32;
  localparam int NQ  = 16;

  logic           clk, rst_b, en, q_empty, rd_ptr_inc, ram_rd_en, out_valid, out_ready;
  logic [BAP-1:0] rd_addr, out_qid;
  logic [BEQ-1:0] rd_ptr_val;
  logic [BAP+BEQ-1:0] ram_rd_addr;
  logic [DW-1:0]  ram_rd_data, out_data;

  packed_q_rd_engine #(
    .BITS_ADDR_PACK  (BAP),
    .NUM_OF_Q        (NQ),
    .BITS_ADDR_EACH_Q(BEQ),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .en         (en),
    .rd_addr    (rd_addr),
    .q_empty    (q_empty),
    .rd_ptr_val (rd_ptr_val),
    .rd_ptr_inc (rd_ptr_inc),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_qid    (out_qid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment model: loaded/base set by the test, popped counted from rd_ptr_inc.
  int             loaded[NQ];
  int             base[NQ];
  int             popped[NQ];
  logic [DW-1:0]  mem[64];
  logic [31:0]    ptr_sum;
  bit             manual, clr_model, clr_mon;
  logic           man_empty;
  logic [BEQ-1:0] man_ptr;

  assign ptr_sum    = base[rd_addr] + popped[rd_addr];
  assign q_empty    = manual ? man_empty : (popped[rd_addr] >= loaded[rd_addr]);
  assign rd_ptr_val = manual ? man_ptr : ptr_sum[BEQ-1:0];

  always @(posedge clk) begin
    if (clr_model) begin
      for (int i = 0; i < NQ; i++) popped[i] <= 0;
    end else if (rd_ptr_inc && !manual) begin
      popped[rd_addr] <= popped[rd_addr] + 1;
    end
  end

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output/issue monitor sampled on the falling edge.
  int             inc_cnt, first_inc_cyc, first_valid_cyc;
  bit             seen_valid;
  logic [BAP-1:0] col_qid[$];
  logic [DW-1:0]  col_data[$];
  int             col_cyc[$];

  always @(negedge clk) begin
    if (clr_mon) begin
      inc_cnt = 0;
      seen_valid = 0;
      col_qid.delete();
      col_data.delete();
      col_cyc.delete();
    end else begin
      if (rd_ptr_inc) begin
        if (inc_cnt == 0) first_inc_cyc = cyc;
        inc_cnt++;
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        col_qid.push_back(out_qid);
        col_data.push_back(out_data);
        col_cyc.push_back(cyc);
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0;
    out_ready = 0;
    manual = 0;
    rst_b = 0;
    clr_mon = 1;
    clr_model = 1;
    for (int i = 0; i < NQ; i++) begin
      loaded[i] = 0;
      base[i] = 0;
    end
    for (int a = 0; a < 64; a++) mem[a] = 32'hB000_0000 + a;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_b = 1;
    clr_mon = 0;
    clr_model = 0;
    tick();
    tick();
  endtask

  task automatic fill_all(input int n);
    for (int i = 0; i < NQ; i++) loaded[i] = n;
  endtask

  function automatic logic [63:0] col_q(input int i);
    return (col_qid.size() > i) ? 64'(col_qid[i]) : 'x;
  endfunction

  function automatic logic [63:0] col_d(input int i);
    return (col_data.size() > i) ? 64'(col_data[i]) : 'x;
  endfunction

  typedef struct {
    logic           en;
    logic           empty;
    logic [BEQ-1:0] ptr;
    logic           exp_inc;
    logic [5:0]     exp_addr;
  } vec_t;

  vec_t   vecs[4];
  entry_t exp_s[17];
  bit     found;

  initial begin
    vecs[0] = '{en: 1'b0, empty: 1'b0, ptr: 2'd1, exp_inc: 1'b0, exp_addr: 6'h01};
    vecs[1] = '{en: 1'b1, empty: 1'b1, ptr: 2'd2, exp_inc: 1'b0, exp_addr: 6'h02};
    vecs[2] = '{en: 1'b1, empty: 1'b0, ptr: 2'd3, exp_inc: 1'b1, exp_addr: 6'h03};
    vecs[3] = '{en: 1'b1, empty: 1'b0, ptr: 2'd0, exp_inc: 1'b1, exp_addr: 6'h00};
    for (int i = 0; i < 17; i++) begin
      exp_s[i].qid  = qid_t'(i % 16);
      exp_s[i].data = 32'hB000_0000 + ((i % 16) * 4) + (i / 16);
    end

    rst_b = 0; en = 0; out_ready = 0; manual = 0; man_empty = 1; man_ptr = '0;
    clr_model = 1; clr_mon = 1;
    for (int i = 0; i < NQ; i++) begin
      loaded[i] = 0;
      base[i] = 0;
    end
    for (int a = 0; a < 64; a++) mem[a] = '0;
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset rd_ptr_inc", 64'(rd_ptr_inc), 64'd0);
    check("reset ram_rd_en", 64'(ram_rd_en), 64'd0);
    check("reset rd_addr", 64'(rd_addr), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_qid", 64'(out_qid), 64'd0);

    // Combinational issue decode with an idle engine at cand 0.
    do_reset();
    manual = 1;
    for (int v = 0; v < 4; v++) begin
      en = vecs[v].en;
      man_empty = vecs[v].empty;
      man_ptr = vecs[v].ptr;
      #1;
      check($sformatf("vec%0d rd_ptr_inc", v), 64'(rd_ptr_inc), 64'(vecs[v].exp_inc));
      check($sformatf("vec%0d ram_rd_en", v), 64'(ram_rd_en), 64'(vecs[v].exp_inc));
      check($sformatf("vec%0d ram_rd_addr", v), 64'(ram_rd_addr), 64'(vecs[v].exp_addr));
    end
    en = 0;
    manual = 0;

    // Sparse queues 3 and 7.
    do_reset();
    mem[13] = 32'hA3; loaded[3] = 1; base[3] = 1;
    mem[30] = 32'hA7; loaded[7] = 1; base[7] = 2;
    out_ready = 1; en = 1;
    repeat (30) tick();
    en = 0;
    repeat (3) tick();
    check("sparse count", 64'(col_qid.size()), 64'd2);
    check("sparse qid0", col_q(0), 64'd3);
    check("sparse data0", col_d(0), 64'hA3);
    check("sparse qid1", col_q(1), 64'd7);
    check("sparse data1", col_d(1), 64'hA7);
    check("sparse pops", 64'(inc_cnt), 64'd2);

    // All queues loaded, full-rate streaming.
    do_reset();
    fill_all(2);
    out_ready = 1; en = 1;
    repeat (22) tick();
    en = 0;
    repeat (4) tick();
    check("stream latency", 64'(first_valid_cyc - first_inc_cyc), 64'd2);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("stream qid%0d", i), col_q(i), 64'(exp_s[i].qid));
      check($sformatf("stream data%0d", i), col_d(i), 64'(exp_s[i].data));
    end
    check("stream back-to-back",
          (col_cyc.size() > 16) ? 64'(col_cyc[16] - col_cyc[0]) : 'x, 64'd16);

    // Backpressure: buffer fills with two pops and holds its head.
    do_reset();
    fill_all(4);
    en = 1;
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall out_data", 64'(out_data), 64'hB000_0000);
      check("stall out_qid", 64'(out_qid), 64'd0);
      tick();
    end
    check("stall pops", 64'(inc_cnt), 64'd2);
    out_ready = 1;
    repeat (4) tick();
    en = 0;
    repeat (4) tick();
    check("release qid0", col_q(0), 64'd0);
    check("release qid1", col_q(1), 64'd1);
    check("release data1", col_d(1), 64'hB000_0004);
    check("release qid2", col_q(2), 64'd2);

    // en drops right after one issue.
    do_reset();
    fill_all(4);
    out_ready = 1; en = 1;
    tick();
    en = 0;
    repeat (6) tick();
    check("en-drop pops", 64'(inc_cnt), 64'd1);
    check("en-drop count", 64'(col_qid.size()), 64'd1);
    check("en-drop qid", col_q(0), 64'd0);
    check("en-drop cand held", 64'(rd_addr), 64'd1);

    // Reset with one read in flight and one entry buffered.
    do_reset();
    fill_all(4);
    en = 1;
    tick();
    tick();
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_b = 0;
    clr_mon = 1;
    #1;
    check("mid-reset out_valid", 64'(out_valid), 64'd0);
    check("mid-reset out_data", 64'(out_data), 64'd0);
    check("mid-reset out_qid", 64'(out_qid), 64'd0);
    check("mid-reset rd_addr", 64'(rd_addr), 64'd0);
    check("mid-reset rd_ptr_inc", 64'(rd_ptr_inc), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_b = 1;
    clr_mon = 0;
    out_ready = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (rd_ptr_inc) found = 1;
    end
    check("post-reset issue seen", 64'(found), 64'd1);
    check("post-reset first rd_addr", 64'(rd_addr), 64'd0);
    repeat (5) tick();
    en = 0;
    repeat (3) tick();
    check("post-reset qid0", col_q(0), 64'd0);
    check("post-reset data0", col_d(0), 64'hB000_0001);

    // Pop from the last queue wraps the scan pointer.
    do_reset();
    loaded[15] = 1; base[15] = 2;
    mem[62] = 32'hC0FF_EE0F;
    out_ready = 1; en = 1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (rd_ptr_inc) found = 1;
    end
    check("wrap issue seen", 64'(found), 64'd1);
    check("wrap rd_addr", 64'(rd_addr), 64'd15);
    check("wrap ram_rd_addr", 64'(ram_rd_addr), 64'h3E);
    tick();
    check("wrap cand next", 64'(rd_addr), 64'd0);
    repeat (3) tick();
    en = 0;
    check("wrap qid", col_q(0), 64'd15);
    check("wrap data", col_d(0), 64'hC0FF_EE0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
